// File: rtl/gray_window_ctrl.sv
// gray_window_ctrl: drives KSIZE-1 registered-read line buffers to turn a
// raster pixel stream into one vertical KSIZE-pixel column per accepted pixel.
// Handshake: a pixel is transferred in every cycle where pix_valid and
// pix_ready are both high. pix_valid may drop at any time. pix_ready depends
// only on the FSM state and never on pix_valid. The column side has no
// backpressure: col_valid is a one-cycle strobe per accepted pixel.

`ifndef CNN_DATA_IN_W
`define CNN_DATA_IN_W 8
`endif
`ifndef CNN_GRAY_BUFFER_ADDR_W
`define CNN_GRAY_BUFFER_ADDR_W 5
`endif

module gray_window_ctrl #(
    parameter int IMG_IN_WIDTH  = 25,
    parameter int IMG_IN_HEIGHT = 25,
    parameter int KSIZE         = 3,
    parameter int ROW_W         = 5
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic                                     pix_valid,
    input  logic [`CNN_DATA_IN_W-1:0]                pix_data,
    output logic                                     pix_ready,
    output logic [KSIZE-2:0]                         lb_w_en,
    output logic [`CNN_GRAY_BUFFER_ADDR_W-1:0]       lb_waddr,
    output logic [`CNN_DATA_IN_W-1:0]                lb_din,
    output logic                                     lb_r_en,
    output logic [`CNN_GRAY_BUFFER_ADDR_W-1:0]       lb_raddr,
    input  logic [(KSIZE-1)*`CNN_DATA_IN_W-1:0]      lb_dout,
    output logic                                     col_valid,
    output logic [KSIZE*`CNN_DATA_IN_W-1:0]          col_data,
    output logic [`CNN_GRAY_BUFFER_ADDR_W-1:0]       col_x,
    output logic [ROW_W-1:0]                         col_y,
    output logic                                     win_valid,
    output logic                                     frame_done,
    output logic                                     busy
);

    localparam int DW  = `CNN_DATA_IN_W;
    localparam int AW  = `CNN_GRAY_BUFFER_ADDR_W;
    localparam int NLB = KSIZE - 1;
    localparam int SW  = (NLB > 1) ? $clog2(NLB) : 1;

    localparam logic [AW-1:0]    X_LAST = AW'(IMG_IN_WIDTH - 1);
    localparam logic [ROW_W-1:0] Y_LAST = ROW_W'(IMG_IN_HEIGHT - 1);
    localparam logic [SW-1:0]    W_LAST = SW'(NLB - 1);
    localparam logic [AW-1:0]    X_WIN  = AW'(KSIZE - 1);
    localparam logic [ROW_W-1:0] Y_WIN  = ROW_W'(KSIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [AW-1:0]    x;
    logic [ROW_W-1:0] y;
    logic [SW-1:0]    wsel;

    logic             acc;
    logic             last_x;
    logic             last_px;

    // Stage-1 registers line up with the one-cycle RAM read latency.
    logic             acc_d;
    logic [DW-1:0]    pix_d;
    logic [AW-1:0]    x_d;
    logic [ROW_W-1:0] y_d;
    logic [SW-1:0]    wsel_d;

    logic [KSIZE*DW-1:0] col_now;
    logic [KSIZE*DW-1:0] col_hold;

    assign pix_ready = (state == RUN);
    assign acc       = pix_ready & pix_valid;
    assign last_x    = (x == X_LAST);
    assign last_px   = last_x & (y == Y_LAST);
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; the final pixel of the frame leads to a single DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (acc && last_px) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Raster counters and write-buffer rotation, advanced once per accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x    <= '0;
            y    <= '0;
            wsel <= '0;
        end else if (state == IDLE && start) begin
            x    <= '0;
            y    <= '0;
            wsel <= '0;
        end else if (acc) begin
            if (last_px) begin
                x    <= '0;
                y    <= '0;
                wsel <= '0;
            end else if (last_x) begin
                x    <= '0;
                y    <= y + ROW_W'(1);
                wsel <= (wsel == W_LAST) ? '0 : wsel + SW'(1);
            end else begin
                x    <= x + AW'(1);
            end
        end
    end

    // Line-buffer strobes: read every buffer at x, overwrite only buffer wsel.
    always_comb begin
        lb_w_en  = '0;
        lb_r_en  = acc;
        lb_waddr = acc ? x : '0;
        lb_raddr = acc ? x : '0;
        lb_din   = acc ? pix_data : '0;
        for (int b = 0; b < NLB; b++) begin
            if (acc && wsel == SW'(b)) lb_w_en[b] = 1'b1;
        end
    end

    // Stage-1 capture of the accepted pixel and its coordinates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_d  <= 1'b0;
            pix_d  <= '0;
            x_d    <= '0;
            y_d    <= '0;
            wsel_d <= '0;
        end else begin
            acc_d <= acc;
            if (acc) begin
                pix_d  <= pix_data;
                x_d    <= x;
                y_d    <= y;
                wsel_d <= wsel;
            end
        end
    end

    // Column assembly: slot j comes from the buffer written j rows ago, zeroed
    // above the top of the frame so stale rows from an earlier frame never leak.
    always_comb begin
        int idx;
        idx = 0;
        col_now = '0;
        col_now[DW-1:0] = pix_d;
        for (int j = 1; j < KSIZE; j++) begin
            idx = (int'(wsel_d) + NLB - j) % NLB;
            if (int'(y_d) >= j) col_now[j*DW +: DW] = lb_dout[idx*DW +: DW];
        end
    end

    // Keeps the last column visible while no new column is being produced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        col_hold <= '0;
        else if (acc_d) col_hold <= col_now;
    end

    assign col_valid  = acc_d;
    assign col_data   = acc_d ? col_now : col_hold;
    assign col_x      = x_d;
    assign col_y      = y_d;
    assign win_valid  = acc_d & (x_d >= X_WIN) & (y_d >= Y_WIN);
    assign frame_done = acc_d & (x_d == X_LAST) & (y_d == Y_LAST);

endmodule

// File: doc/gray_window_ctrl.md
Name: gray_window_ctrl

Overview:
- Sequences the gray line-buffer RAMs (registered-read, write-enabled dual-port instances) to build a sliding KSIZE-row column from a raster pixel stream.
- Owns the KSIZE-1 line-buffer instances' address/enable/data lines and rotates the write target per image row.
- Emits one vertical column of KSIZE pixels per accepted pixel to the downstream convolution window register.

Parameters:
- IMG_IN_WIDTH, 25, pixels per row; also the depth of each line buffer.
- IMG_IN_HEIGHT, 25, rows per frame.
- KSIZE, 3, kernel height. Number of line buffers NLB = KSIZE-1. Legal range is 2..8.
- ROW_W, 5, width of the row counter. Must satisfy 2^ROW_W >= IMG_IN_HEIGHT.

Ports:
- clk  in  1  single clock; all RAMs share it.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; starts a frame. Honoured only in IDLE.
- pix_valid  in  1  input pixel valid.
- pix_data  in  `CNN_DATA_IN_W  input pixel.
- pix_ready  out  1  controller accepts a pixel. Acceptance is pix_valid & pix_ready.
- lb_w_en  out  NLB  per-buffer write enable.
- lb_waddr  out  `CNN_GRAY_BUFFER_ADDR_W  shared write address.
- lb_din  out  `CNN_DATA_IN_W  shared write data.
- lb_r_en  out  1  read enable to all buffers.
- lb_raddr  out  `CNN_GRAY_BUFFER_ADDR_W  shared read address.
- lb_dout  in  NLB*`CNN_DATA_IN_W  buffer b read data at bits [b*DW +: DW].
- col_valid  out  1  column output valid.
- col_data  out  KSIZE*`CNN_DATA_IN_W  slot j (bits [j*DW +: DW]) is the pixel from row y-j. Slot 0 is the current row.
- col_x  out  `CNN_GRAY_BUFFER_ADDR_W  column x of col_data.
- col_y  out  ROW_W  column y of col_data.
- win_valid  out  1  col_valid & col_x>=KSIZE-1 & col_y>=KSIZE-1.
- frame_done  out  1  one-cycle pulse, coincident with the last column.
- busy  out  1  state != IDLE.

Behaviour:
Reset:
- State = IDLE; x, y, wsel = 0.
- All outputs = 0, including pix_ready, col_data, lb_* and frame_done.
- Line-buffer RAM contents are not cleared.

States: IDLE, RUN, DONE.
- IDLE:
  - pix_ready=0.
  - On start: x=0, y=0, wsel=0, go to RUN.
- RUN:
  - pix_ready=1. No backpressure from downstream.
  - On acceptance, all in the same cycle (lb_* driven combinationally from the counters):
    - lb_r_en=1, lb_raddr=x.
    - lb_w_en[wsel]=1, lb_waddr=x, lb_din=pix_data.
    - Other lb_w_en bits = 0.
  - Without acceptance: lb_r_en=0, lb_w_en=0, counters hold.
- Counter update on acceptance:
  - If x=IMG_IN_WIDTH-1: x=0, y=y+1, wsel=(wsel+1) mod NLB.
  - Otherwise: x=x+1.
  - On the last pixel (x=IMG_IN_WIDTH-1, y=IMG_IN_HEIGHT-1): go to DONE instead.
- DONE:
  - pix_ready=0.
  - Exactly one cycle, then IDLE.
- start outside IDLE is ignored.

RAM collision and output alignment:
- Same-address read and write in one cycle returns the OLD contents (read-first).
  - Buffer wsel therefore still yields row y-NLB while it is being overwritten.
- Stage-1 registers, loaded on acceptance: pixel, x, y, wsel, plus an acc_d flag. They align with RAM read latency.
- The cycle after an acceptance:
  - col_valid=1.
  - col_x and col_y = the registered x and y.
  - slot0 = registered pixel.
  - For j=1..NLB: slot j = lb_dout of buffer (wsel_d + NLB - j) mod NLB.
- Zero padding: slot j is forced to 0 when col_y < j. This covers top-of-frame rows and stale RAM from a previous frame.
- col_data, col_x and col_y hold their last values when col_valid=0.
- frame_done=1 in the cycle carrying the column for (W-1, H-1), which is the DONE cycle.

Latency and throughput:
- Latency is 1 cycle, acceptance to col_valid.
- Throughput is 1 pixel per clock. Gaps in pix_valid produce gaps in col_valid.

Reset mid-frame:
- Immediate return to IDLE; all outputs 0.
- A pending column is discarded and no frame_done is issued.

Test Plan:
1. Assert rst for 3 cycles, then release with no stimulus -> every output 0, busy=0, pix_ready=0.
2. W=4, H=4, K=3. Pulse start, then stream pix_data=y*4+x with pix_valid continuously high -> one cycle after accepting (2,2): col_valid=1, col_data slots {0:10, 1:6, 2:2}, win_valid=1, col_x=2, col_y=2.
3. Same frame, top rows -> column for (1,0) gives slots {1,0,0}. Column for (1,1) gives slots {5,1,0}. win_valid=0 on both.
4. Drop pix_valid for 3 cycles mid-row after (1,2) -> col_valid=0 for those 3 cycles, no lb_w_en, x/y hold. The next pixel continues at (2,2) with correct data.
5. Finish the frame -> frame_done=1 together with the (3,3) column. pix_ready=0 from that cycle, busy=0 the following cycle. A second frame started with values +100 shows slots 1 and 2 = 0 in row 0, never stale data from frame 1.
6. Assert rst asynchronously after 6 accepted pixels -> outputs 0 immediately. A new start restarts at (0,0) with zero padding, and no frame_done is issued for the aborted frame.
